updown_ctrl: RTL and testbench

//  Command-driven master for the 4-bit-style loadable up/down counter interface
//  (load/control/data_in out, count in). Accepts LOAD and SEEK commands over a

---
 rtl/updown_pkg.sv | 17 +
 rtl/updown_dir_calc.sv | 22 ++
 rtl/updown_ctrl.sv | 143 ++++++++++++++
 tb/tb_updown_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// Shared encodings and defaults for the up/down counter controller.
package updown_pkg;

    localparam int DEF_W         = 4;
    localparam int DEF_TMO_EXTRA = 2;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_SEEK = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_SEEK   = 2'd3
    } state_e;

endpackage

// File: rtl/updown_dir_calc.sv
// Seek direction from current count and target (1 = up).
// UPDOWN_WRAP_SEEK_EN selects the shortest modular path instead of magnitude compare.
module updown_dir_calc #(
    parameter int W = 4
) (
    input  logic [W-1:0] count_i,
    input  logic [W-1:0] target_i,
    output logic         dir_o
);

`ifdef UPDOWN_WRAP_SEEK_EN
    localparam logic [W-1:0] HALF = W'(2**(W-1));
    logic [W-1:0] d_up;

    // Equal distance both ways resolves to up.
    assign d_up  = target_i - count_i;
    assign dir_o = (d_up <= HALF);
`else
    assign dir_o = (target_i > count_i);
`endif

endmodule

// File: rtl/updown_ctrl.sv
// Command-driven master for a loadable up/down counter: LOAD/SEEK then hold.
// Build option UPDOWN_WRAP_SEEK_EN lets SEEK take the shortest path through wrap.
module updown_ctrl
    import updown_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int TMO_EXTRA = DEF_TMO_EXTRA
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic         cmd_op_i,
    input  logic [W-1:0] cmd_data_i,
    input  logic [W-1:0] count_i,
    output logic         load_o,
    output logic         control_o,
    output logic [W-1:0] data_in_o,
    output logic         done_o,
    output logic         err_o
);

    // state  | meaning
    // IDLE   | counter held at hold_q, accepting commands
    // LOAD   | one-cycle load of tgt_q
    // VERIFY | check counter took tgt_q
    // SEEK   | stepping toward tgt_q, bounded by tmo_q

    localparam int              TW       = $clog2(2**W + TMO_EXTRA) + 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(2**W + TMO_EXTRA - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  hold_q, hold_d;
    logic [W-1:0]  tgt_q, tgt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          dir_q, dir_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          dir_new;
    logic          at_tgt;

    assign at_tgt = (count_i == tgt_q);

    updown_dir_calc #(.W(W)) u_dir (
        .count_i  (count_i),
        .target_i (cmd_data_i),
        .dir_o    (dir_new)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            tgt_q   <= '0;
            tmo_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tgt_q   <= tgt_d;
            tmo_q   <= tmo_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tgt_d   = tgt_q;
        tmo_d   = tmo_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    tgt_d = cmd_data_i;
                    if (cmd_op_i == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (count_i == cmd_data_i) begin
                        done_d = 1'b1;
                        hold_d = cmd_data_i;
                    end else begin
                        state_d = ST_SEEK;
                        tmo_d   = '0;
                        dir_d   = dir_new;
                    end
                end
            end
            ST_LOAD: state_d = ST_VERIFY;
            ST_VERIFY: begin
                done_d  = at_tgt;
                err_d   = !at_tgt;
                hold_d  = tgt_q;
                state_d = ST_IDLE;
            end
            ST_SEEK: begin
                if (at_tgt) begin
                    done_d  = 1'b1;
                    hold_d  = tgt_q;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    // Counter not tracking: park it wherever it currently sits.
                    if (tmo_q == TMO_LAST) begin
                        err_d   = 1'b1;
                        hold_d  = count_i;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = 1'b0;
        load_o      = 1'b1;
        control_o   = 1'b0;
        data_in_o   = tgt_q;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                data_in_o   = hold_q;
            end
            ST_SEEK: begin
                if (!at_tgt) begin
                    load_o    = 1'b0;
                    control_o = dir_q;
                end
            end
            default: ;
        endcase
    end

    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_updown_ctrl.sv
module tb_updown_ctrl;
    import updown_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] count = 4'hA;
    logic       load;
    logic       control;
    logic [3:0] data_in;
    logic       done;
    logic       err;
    logic       stuck = 1'b0;

    typedef struct {
        bit         is_err;
        logic [3:0] cnt;
        int         lat;
        int         up;
        int         dn;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural counter; stuck freezes it to emulate a broken part.
    always @(posedge clk) begin
        if (!stuck) begin
            if (load)         count <= data_in;
            else if (control) count <= count + 4'd1;
            else              count <= count - 4'd1;
        end
    end

    updown_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_data_i  (cmd_data),
        .count_i     (count),
        .load_o      (load),
        .control_o   (control),
        .data_in_o   (data_in),
        .done_o      (done),
        .err_o       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_load(input logic [3:0] tgt, input bit bad, input logic [3:0] cnt);
        exp_t e;
        e.is_err = bad; e.cnt = cnt; e.lat = 3; e.up = 0; e.dn = 0;
        sb.push_back(e);
    endfunction

    function automatic void push_seek(input logic [3:0] from, input logic [3:0] to);
        exp_t e;
        logic [3:0] d_up;
        e.is_err = 1'b0; e.cnt = to; e.up = 0; e.dn = 0;
`ifdef UPDOWN_WRAP_SEEK_EN
        d_up = to - from;
        if (d_up <= 4'd8) e.up = int'(d_up);
        else              e.dn = 16 - int'(d_up);
`else
        d_up = 4'd0;
        if (to > from) e.up = int'(to) - int'(from);
        else           e.dn = int'(from) - int'(to);
`endif
        e.lat = (from == to) ? 1 : e.up + e.dn + 2;
        sb.push_back(e);
    endfunction

    // Called on a negedge with the DUT idle; returns on the negedge after the handshake edge.
    task automatic issue(input logic op, input logic [3:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        check("cmd_ready", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = ~data;
    endtask

    task automatic wait_result(input int budget, input bit inject);
        exp_t e;
        int   up = 0;
        int   dn = 0;
        bit   seen = 1'b0;
        for (int k = 1; k <= budget && !seen; k++) begin
            if (inject && k == 2) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_LOAD;
                cmd_data  = 4'h0;
                check("busy_ready", cmd_ready, 0);
            end
            if (inject && k == 3) cmd_valid = 1'b0;
            if (done || err) begin
                e = sb.pop_front();
                seen = 1'b1;
                check("excl", done && err, 0);
                check("is_err", err, e.is_err);
                check("count", count, e.cnt);
                check("latency", k, e.lat);
                check("up_steps", up, e.up);
                check("dn_steps", dn, e.dn);
            end else begin
                if (!load) begin
                    if (control) up++;
                    else         dn++;
                end
                @(negedge clk);
            end
        end
        check("result_seen", seen, 1);
        if (!seen && sb.size() > 0) void'(sb.pop_front());
    endtask

    initial begin
        bit ok;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_LOAD;
        cmd_data  = 4'h0;

        // 1: reset
        repeat (2) @(negedge clk);
        check("rst_load", load, 1);
        check("rst_data_in", data_in, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_ready", cmd_ready, 1);

        // 2: LOAD 5
        push_load(4'd5, 1'b0, 4'd5);
        issue(OP_LOAD, 4'd5);
        check("load_strobe", load, 1);
        check("load_value", data_in, 5);
        wait_result(10, 1'b0);

        // 3: SEEK 9 from 5, then hold
        push_seek(4'd5, 4'd9);
        issue(OP_SEEK, 4'd9);
        wait_result(30, 1'b0);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (count !== 4'd9 || done || err) ok = 1'b0;
        end
        check("hold9", ok, 1);
        push_seek(4'd9, 4'd9);
        issue(OP_SEEK, 4'd9);
        wait_result(5, 1'b0);

        // 4: SEEK 2 from 14, tie case, and a wrap-eligible downward seek
        push_load(4'd14, 1'b0, 4'd14);
        issue(OP_LOAD, 4'd14);
        wait_result(10, 1'b0);
        push_seek(4'd14, 4'd2);
        issue(OP_SEEK, 4'd2);
        wait_result(30, 1'b0);
        push_seek(4'd2, 4'd10);
        issue(OP_SEEK, 4'd10);
        wait_result(30, 1'b0);
        push_seek(4'd10, 4'd1);
        issue(OP_SEEK, 4'd1);
        wait_result(30, 1'b0);

        // 5: stuck counter -> SEEK timeout, LOAD verify failure
        stuck = 1'b1;
        sb.push_back('{is_err: 1'b1, cnt: 4'd1, lat: 19, up: 18, dn: 0});
        issue(OP_SEEK, 4'd7);
        wait_result(40, 1'b0);
        check("tmo_ready", cmd_ready, 1);
        check("tmo_hold", data_in, 1);
        push_load(4'd5, 1'b1, 4'd1);
        issue(OP_LOAD, 4'd5);
        wait_result(10, 1'b0);
        check("verr_hold", data_in, 5);
        stuck = 1'b0;

        // 6: SEEK 3 from 12 with a command ignored mid-seek, then reset mid-seek
        push_load(4'd12, 1'b0, 4'd12);
        issue(OP_LOAD, 4'd12);
        wait_result(10, 1'b0);
        push_seek(4'd12, 4'd3);
        issue(OP_SEEK, 4'd3);
        wait_result(30, 1'b1);
        push_seek(4'd3, 4'd12);
        issue(OP_SEEK, 4'd12);
        wait_result(30, 1'b0);
        issue(OP_SEEK, 4'd3);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_load", load, 1);
        check("abort_data_in", data_in, 0);
        rst_n = 1'b1;
        ok = 1'b1;
        @(negedge clk);
        check("abort_count", count, 0);
        repeat (4) begin
            if (done || err) ok = 1'b0;
            @(negedge clk);
        end
        check("abort_quiet", ok, 1);
        check("abort_ready", cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
